pe_sequencer: RTL and testbench

- Control-side initiator for the GF(3^97) processing element (PE).
- Accepts an operation request (multiply, or n-fold cube) over a start/done handshake.
- Drives the PE's 11-bit control word {c0..c10}, cycle by cycle, for the whole operation.
- Flags the single cycle in which the PE output holds the result; the PE clears its result register on any cycle where c10=0, so the result is visible for one cycle only.

---
 rtl/pe_pkg.sv | 24 ++
 rtl/pe_ctrl_decode.sv | 24 ++
 rtl/pe_sequencer.sv | 85 ++++++++
 tb/tb_pe_sequencer.sv | 158 +++++++++++++++
 4 files changed

// File: rtl/pe_pkg.sv
// Shared constants for the GF(3^97) processing element and its control sequencers.
// Control word bit 10 is c0 and bit 0 is c10.
package pe_pkg;

   localparam int unsigned CTRL_W = 11;

   localparam logic [CTRL_W-1:0] CW_IDLE  = 11'h000;
   localparam logic [CTRL_W-1:0] CW_LOAD  = 11'h7C0;
   localparam logic [CTRL_W-1:0] CW_MITER = 11'h03F;
   localparam logic [CTRL_W-1:0] CW_CSTEP = 11'h280;
   localparam logic [CTRL_W-1:0] CW_CLAST = 11'h281;

   localparam logic OP_MULT = 1'b0;
   localparam logic OP_CUBE = 1'b1;

   typedef logic [2:0] state_t;

   localparam state_t ST_IDLE = 3'd0;
   localparam state_t ST_LOAD = 3'd1;
   localparam state_t ST_MULT = 3'd2;
   localparam state_t ST_CUBE = 3'd3;
   localparam state_t ST_DONE = 3'd4;

endpackage

// File: rtl/pe_ctrl_decode.sv
// Purely combinational decode of sequencer state and counter into the PE control word.
// i_last is the counter value of the final cube step (n-1).
module pe_ctrl_decode
   import pe_pkg::*;
#(
   parameter int unsigned CNT_W = 6
) (
   input  logic [2:0]        i_state,
   input  logic [CNT_W-1:0]  i_cnt,
   input  logic [CNT_W-1:0]  i_last,
   output logic [CTRL_W-1:0] o_ctrl
);

   always_comb begin
      o_ctrl = CW_IDLE;
      case (i_state)
         ST_LOAD: o_ctrl = CW_LOAD;
         ST_MULT: o_ctrl = CW_MITER;
         ST_CUBE: o_ctrl = (i_cnt == i_last) ? CW_CLAST : CW_CSTEP;
         default: o_ctrl = CW_IDLE;
      endcase
   end

endmodule

// File: rtl/pe_sequencer.sv
// Start/done initiator for the GF(3^97) PE: runs one multiply or an n-fold cube,
// driving the control word each cycle and pulsing done in the single result-valid cycle.
module pe_sequencer
   import pe_pkg::*;
#(
   parameter int unsigned MULT_ITERS = 33,
   parameter int unsigned CNT_W      = 6
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              start,
   input  logic              op,
   input  logic [5:0]        cube_n,
   output logic              busy,
   output logic              done,
   output logic [CTRL_W-1:0] ctrl
);

   state_t           r_state;
   logic [CNT_W-1:0] r_cnt;
   logic [CNT_W-1:0] r_last;
   logic             r_op;

   logic             w_mult_end;
   logic             w_cube_end;
   logic [CNT_W-1:0] w_last_in;

   assign w_mult_end = (r_cnt == CNT_W'(MULT_ITERS - 1));
   assign w_cube_end = (r_cnt == r_last);
   // A cube count of 0 runs as a single step, so the final counter value is 0 too.
   assign w_last_in  = (cube_n == 6'd0) ? '0 : CNT_W'(cube_n - 6'd1);

   always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
         r_state <= ST_IDLE;
         r_cnt   <= '0;
         r_last  <= '0;
         r_op    <= OP_MULT;
      end else begin
         case (r_state)
            ST_IDLE: begin
               if (start) begin
                  r_op    <= op;
                  r_last  <= w_last_in;
                  r_state <= ST_LOAD;
               end
            end
            ST_LOAD: begin
               r_cnt   <= '0;
               r_state <= (r_op == OP_CUBE) ? ST_CUBE : ST_MULT;
            end
            ST_MULT: begin
               if (w_mult_end) begin
                  r_cnt   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            ST_CUBE: begin
               if (w_cube_end) begin
                  r_cnt   <= '0;
                  r_state <= ST_DONE;
               end else begin
                  r_cnt <= r_cnt + 1'b1;
               end
            end
            default: r_state <= ST_IDLE;
         endcase
      end
   end

   assign busy = (r_state != ST_IDLE);
   assign done = (r_state == ST_DONE);

   pe_ctrl_decode #(
      .CNT_W (CNT_W)
   ) u_decode (
      .i_state (r_state),
      .i_cnt   (r_cnt),
      .i_last  (r_last),
      .o_ctrl  (ctrl)
   );

endmodule

// File: tb/tb_pe_sequencer.sv
// Directed bench for pe_sequencer: control-word profile, busy/done timing, start handling
// and asynchronous abort, all against hand-derived cycle tables.
module tb_pe_sequencer;

   logic        clk;
   logic        reset;
   logic        start;
   logic        op;
   logic [5:0]  cube_n;
   logic        busy;
   logic        done;
   logic [10:0] ctrl;

   int n_checks;
   int n_fail;

   pe_sequencer dut (
      .clk    (clk),
      .reset  (reset),
      .start  (start),
      .op     (op),
      .cube_n (cube_n),
      .busy   (busy),
      .done   (done),
      .ctrl   (ctrl)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_checks++;
      if (got !== exp) begin
         n_fail++;
         $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
      end
   endtask

   // Expected control word in cycle cyc (cycle 1 = LOAD); n is the effective cube count.
   function automatic logic [10:0] exp_ctrl(input bit is_cube, input int n, input int cyc);
      if (cyc == 1) return 11'h7C0;
      if (!is_cube) return (cyc >= 2 && cyc <= 34) ? 11'h03F : 11'h000;
      if (cyc >= 2 && cyc <= n) return 11'h280;
      if (cyc == n + 1) return 11'h281;
      return 11'h000;
   endfunction

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   // Issue one operation and compare every cycle through one cycle past done.
   // If pulse_busy is set, start is pulsed in cycles 5 and 20 and must be ignored.
   task automatic run_op(input string name, input bit is_cube, input int n_in,
                         input bit pulse_busy);
      int n_eff;
      int dcyc;
      int n_done;
      n_eff  = (n_in == 0) ? 1 : n_in;
      dcyc   = is_cube ? n_eff + 2 : 35;
      n_done = 0;
      start  = 1'b1;
      op     = is_cube;
      cube_n = 6'(n_in);
      step();
      start  = 1'b0;
      op     = ~is_cube;
      cube_n = 6'd63;
      for (int cyc = 1; cyc <= dcyc + 1; cyc++) begin
         check($sformatf("%s ctrl c%0d", name, cyc), 32'(ctrl), 32'(exp_ctrl(is_cube, n_eff, cyc)));
         check($sformatf("%s busy c%0d", name, cyc), 32'(busy), 32'(cyc <= dcyc));
         check($sformatf("%s done c%0d", name, cyc), 32'(done), 32'(cyc == dcyc));
         if (done) n_done++;
         start = pulse_busy && (cyc == 5 || cyc == 20);
         step();
      end
      start = 1'b0;
      check({name, " done count"}, 32'(n_done), 32'd1);
   endtask

   initial begin
      int k;
      int n_done;
      n_checks = 0;
      n_fail   = 0;
      reset    = 1'b1;
      start    = 1'b0;
      op       = 1'b0;
      cube_n   = 6'd0;
      #3;
      check("reset ctrl", 32'(ctrl), 32'h0);
      check("reset busy", 32'(busy), 32'h0);
      check("reset done", 32'(done), 32'h0);
      step();
      reset = 1'b0;
      step();

      run_op("mult", 1'b0, 0, 1'b1);
      run_op("cube5", 1'b1, 5, 1'b0);
      run_op("cube0", 1'b1, 0, 1'b0);
      run_op("cube1", 1'b1, 1, 1'b0);
      step();

      // Start held high: one idle cycle after done, next LOAD in cycle 37.
      start = 1'b1;
      op    = 1'b0;
      step();
      for (int cyc = 1; cyc <= 37; cyc++) begin
         if (cyc == 35) check("held done c35", 32'(done), 32'd1);
         if (cyc == 36) begin
            check("held idle ctrl", 32'(ctrl), 32'h0);
            check("held idle busy", 32'(busy), 32'd0);
         end
         if (cyc == 37) begin
            check("held reload ctrl", 32'(ctrl), 32'h7C0);
            check("held reload busy", 32'(busy), 32'd1);
         end
         if (cyc < 37) step();
      end
      start = 1'b0;
      k = 0;
      while (!done && k < 100) begin
         step();
         k++;
      end
      check("held second done", 32'(done), 32'd1);
      step();
      step();

      // Asynchronous abort mid-multiply at counter=10 (cycle 12).
      start = 1'b1;
      op    = 1'b0;
      step();
      start = 1'b0;
      for (int cyc = 1; cyc < 12; cyc++) step();
      check("abort pre ctrl", 32'(ctrl), 32'h03F);
      #2;
      reset = 1'b1;
      #1;
      check("abort ctrl", 32'(ctrl), 32'h0);
      check("abort busy", 32'(busy), 32'd0);
      check("abort done", 32'(done), 32'd0);
      step();
      reset  = 1'b0;
      n_done = 0;
      for (int cyc = 0; cyc < 40; cyc++) begin
         if (done || busy) n_done++;
         step();
      end
      check("abort no activity", 32'(n_done), 32'd0);
      run_op("post-abort cube3", 1'b1, 3, 1'b0);

      $display("TB_RESULT checks=%0d failures=%0d", n_checks, n_fail);
      $finish;
   end

endmodule
